// File: rtl/pwm_player_pkg.sv
// Shared types and constants for the PWM DAC player.
package pwm_player_pkg;

  localparam int unsigned CODE_WIDTH = 10;
  localparam int unsigned MAX        = (1 << CODE_WIDTH) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_window_counter.sv
// PWM window counter: counts 0..2^CODE_WIDTH-1, flags the last cycle of the
// window and compares the count against the active code to form the raw PWM bit.
module pwm_window_counter #(
  parameter int unsigned CODE_WIDTH = pwm_player_pkg::CODE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  input  logic [CODE_WIDTH-1:0] active_code,
  output logic [CODE_WIDTH-1:0] count,
  output logic                  at_max,
  output logic                  pwm_raw
);

  // Window position; wraps naturally from all-ones back to zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (advance) begin
      count <= count + CODE_WIDTH'(1);
    end
  end

  assign at_max  = &count;
  assign pwm_raw = (count < active_code);

endmodule

// File: rtl/pwm_dac_player.sv
// PWM DAC player: pulls one code per window from the tone generator and
// renders it as a 2^CODE_WIDTH-cycle PWM window on pwm_out.
// Build option: define PWM_PLAYER_STATS_EN to enable the pulled-sample counter
// on sample_count; otherwise sample_count is tied to zero.
module pwm_dac_player #(
  parameter int unsigned CODE_WIDTH = pwm_player_pkg::CODE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [CODE_WIDTH-1:0] code,
  output logic                  next_sample,
  output logic                  pwm_out,
  output logic                  busy,
  output logic [31:0]           sample_count
);

  import pwm_player_pkg::*;

  state_t                  state;
  logic [CODE_WIDTH-1:0]   active_code;
  logic [CODE_WIDTH-1:0]   count;
  logic                    at_max;
  logic                    pwm_raw;

  // Count only while rendering; IDLE and PRIME hold the window at zero.
  pwm_window_counter #(
    .CODE_WIDTH (CODE_WIDTH)
  ) u_window (
    .clk         (clk),
    .rst         (rst),
    .clear       (state != RUN),
    .advance     (state == RUN),
    .active_code (active_code),
    .count       (count),
    .at_max      (at_max),
    .pwm_raw     (pwm_raw)
  );

  // Player FSM; the code is latched only on pull edges.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      active_code <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) state <= PRIME;
        end
        PRIME: begin
          active_code <= code;
          state       <= RUN;
        end
        RUN: begin
          if (at_max) begin
            if (enable) active_code <= code;
            else        state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign next_sample = (state == PRIME) | ((state == RUN) & at_max & enable);
  assign pwm_out     = (state == RUN) & pwm_raw;
  assign busy        = (state != IDLE);

`ifdef PWM_PLAYER_STATS_EN
  logic [31:0] stats_q;

  // Tally of every pull strobe since reset; wraps at 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stats_q <= 32'd0;
    end else if (next_sample) begin
      stats_q <= stats_q + 32'd1;
    end
  end

  assign sample_count = stats_q;
`else
  assign sample_count = 32'd0;
`endif

endmodule

// File: tb/tb_pwm_dac_player.sv
// Scoreboard bench for pwm_dac_player: expected per-window high counts are
// queued by the stimulus; a negedge monitor measures each window and compares.
module tb_pwm_dac_player;

  localparam int unsigned W   = 10;
  localparam int          WIN = 1 << W;

  logic         clk;
  logic         rst;
  logic         enable;
  logic [W-1:0] code;
  logic         next_sample;
  logic         pwm_out;
  logic         busy;
  logic [31:0]  sample_count;

  typedef struct packed {
    logic [31:0] hi;
    logic        pull;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef PWM_PLAYER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  pwm_dac_player #(.CODE_WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .code         (code),
    .next_sample  (next_sample),
    .pwm_out      (pwm_out),
    .busy         (busy),
    .sample_count (sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_win(input int hi, input bit pull);
    exp_t e;
    e.hi   = 32'(hi);
    e.pull = pull;
    sb.push_back(e);
  endtask

  // Wait for a pull strobe, then step past its edge.
  task automatic wait_pull();
    int n = 0;
    @(negedge clk);
    while (!next_sample && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!next_sample) begin
      n_cmp++;
      n_err++;
      $display("FAIL pull_timeout: got no pull within %0d cycles", n);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: measure each window opened by a pull and score it.
  bit   win_open = 1'b0;
  int   win_cyc  = 0;
  int   win_hi   = 0;
  int   win_idx  = 0;
  logic prev_ns  = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      win_open = 1'b0;
      prev_ns  = 1'b0;
    end else begin
      if (win_open) begin
        if (pwm_out) win_hi++;
        win_cyc++;
        if (win_cyc == WIN) begin
          exp_t e;
          win_open = 1'b0;
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_underflow: window %0d high=%0d with no expectation", win_idx, win_hi);
          end else begin
            e = sb.pop_front();
            chk($sformatf("win%0d_high", win_idx), 32'(win_hi), e.hi);
            chk($sformatf("win%0d_pull_at_end", win_idx), 32'(next_sample), 32'(e.pull));
          end
          win_idx++;
        end
      end
      if (next_sample) begin
        chk("pull_width", 32'(prev_ns), 32'd0);
        win_open = 1'b1;
        win_cyc  = 0;
        win_hi   = 0;
      end
      prev_ns = next_sample;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  int wcodes[9] = '{256, 256, 256, 256, 256, 0, 1023, 1, 300};

  initial begin
    rst    = 1'b0;
    enable = 1'b1;
    code   = W'(256);

    // Reset held with enable high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_next_sample", 32'(next_sample), 32'd0);
    chk("rst_pwm_out", 32'(pwm_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sample_count", sample_count, 32'd0);

    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("release_idle_no_pull", 32'(next_sample), 32'd0);
    @(negedge clk);
    chk("release_prime_pull", 32'(next_sample), 32'd1);
    chk("release_prime_busy", 32'(busy), 32'd1);

    // Windows 0..8; window 8 ends with enable dropped
    for (int k = 0; k < 9; k++) push_win(wcodes[k], k < 8);

    @(posedge clk); #1;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) wait_pull();
      repeat (3) @(posedge clk);
      #1;
      code = (k < 8) ? W'(wcodes[k+1]) : W'(999);
    end
    repeat (97) @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (924) @(posedge clk);
    @(negedge clk);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_next_sample", 32'(next_sample), 32'd0);
    chk("drop_pwm_out", 32'(pwm_out), 32'd0);
    chk("drop_sample_count", sample_count, STATS ? 32'd9 : 32'd0);

    // Re-enable, then reset mid-window at count 500 with code 700
    @(posedge clk); #1;
    code   = W'(700);
    enable = 1'b1;
    @(negedge clk);
    chk("reen_idle_no_pull", 32'(next_sample), 32'd0);
    @(negedge clk);
    chk("reen_prime_pull", 32'(next_sample), 32'd1);
    @(posedge clk); #1;
    repeat (500) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_pwm_before_rst", 32'(pwm_out), 32'd1);
    chk("mid_no_pull_before_rst", 32'(next_sample), 32'd0);
    @(negedge clk);
    chk("mid_rst_pwm_out", 32'(pwm_out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_next_sample", 32'(next_sample), 32'd0);
    chk("mid_rst_sample_count", sample_count, 32'd0);

    // Square-wave producer: 11 pulls (PRIME + 10 wraps), then stop
    code = W'(100);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int j = 0; j < 11; j++) push_win((j % 2 == 0) ? 100 : 900, j < 10);
    for (int p = 0; p < 11; p++) begin
      wait_pull();
      code = (code == W'(100)) ? W'(900) : W'(100);
    end
    enable = 1'b0;
    @(negedge clk);
    chk("stats_sample_count", sample_count, STATS ? 32'd11 : 32'd0);
    repeat (1024) @(posedge clk);
    @(negedge clk);
    chk("stats_end_busy", 32'(busy), 32'd0);
    chk("stats_end_next_sample", 32'(next_sample), 32'd0);
    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
